alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational 64-bit integer ALU between NREQ requesters (issue slots / AGU / branch unit).
//  - Round-robin arbitration; valid/ready request and response channels; one op per cycle throughput.
//  - Two register stages: EX (registered ALU inputs) and RSP (captured ALU result, tagged with requester id).
//  - Sits between the issue logic and the ALU instance; the ALU stays purely combinational.
// PARAMETERS
//  WIDTH   64  datapath width; ALU operand and result width
//  NREQ    4   number of requesters, 2..8
//  IDW     2   requester id width, = clog2(NREQ)
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           synchronous reset, active low
//  req_valid      in   NREQ        per-requester op valid
//  req_ready      out  NREQ        per-requester accept; one-hot or zero
//  req_op_a       in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_op_b       in   NREQ*WIDTH  operand B, same packing
//  req_ctrl       in   NREQ*5      ALU control code, requester i at [i*5 +: 5]
//  alu_operand_a  out  WIDTH       to ALU, driven from EX register
//  alu_operand_b  out  WIDTH       to ALU, driven from EX register
//  alu_control    out  5           to ALU, driven from EX register
//  alu_result     in   WIDTH       from ALU, combinational on EX register
//  alu_zero       in   1           from ALU zero flag
//  rsp_valid      out  1           response valid
//  rsp_ready      in   1           response consumer accept
//  rsp_id         out  IDW         id of the requester that issued the op
//  rsp_result     out  WIDTH       captured ALU result
//  rsp_zero       out  1           captured zero flag
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): rr_ptr=0, ex_valid=0, rsp_valid=0; all EX/RSP data regs and outputs = 0.
//    req_ready=0 while rst_n=0. Reset mid-operation discards in-flight ops; no response is produced.
//  - Advance conditions:
//    - rsp_free = !rsp_valid | rsp_ready
//    - ex_adv   = !ex_valid | rsp_free
//  - Arbitration (combinational):
//    - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    - req_ready[i] = ex_adv & grant==i & req_valid[i]. req_ready does not depend combinationally on req_valid of others beyond the grant.
//  - Accept (req_valid[i]&req_ready[i]):
//    - EX <= {op_a, op_b, ctrl, id=i}, ex_valid <= 1.
//    - rr_ptr <= (i+1) mod NREQ.
//    - rr_ptr is unchanged when nothing is accepted.
//  - ex_adv with no accept: ex_valid <= 0.
//  - EX->RSP (ex_valid & rsp_free): RSP <= {alu_result, alu_zero, ex_id}, rsp_valid <= 1.
//  - rsp_valid & rsp_ready with no EX->RSP transfer: rsp_valid <= 0.
//  - Latency: accept at edge T -> rsp_valid high after edge T+1 (2 edges). Full throughput 1 op/cycle when rsp_ready=1.
//  - Backpressure:
//    - rsp_ready=0 with both stages full -> req_ready=0; EX and RSP hold their values stable.
//    - At most 2 ops are in flight.
//  - Simultaneous events: RSP drain and EX->RSP in the same cycle is legal (pipelined). EX refill in the same cycle is also legal.
//  - Ordering: responses return in acceptance order. The rsp_id sequence equals the grant sequence.
//  - req_ctrl codes are passed through unchecked. Undefined codes yield the ALU's result (0) with rsp_zero=1.
//  - Fairness: a requester holding req_valid is granted within NREQ accepts.
// CONFIGURATION
//  ALU_OPISO_EN (operand isolation, low power):
//   - defined: EX operand/ctrl regs load only on an accept. While ex_valid=0, alu_operand_a/b/control are forced to 0 (ADD 0+0), so the ALU does not toggle on idle cycles.
//   - undefined: EX regs load the granted (or rr_ptr-selected) requester's buses on every cycle where ex_adv=1, valid or not. ALU inputs follow bus activity (smaller mux, higher power).
//   - Protocol, latency and rsp_* values are identical in both builds.
// TESTING
//  1. Single op: req0 ADD a=5,b=7 (ctrl 00000) -> rsp_valid 2 edges later, rsp_result=12, rsp_id=0, rsp_zero=0.
//  2. Round robin: all 4 req_valid held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1. One response per cycle after fill.
//  3. Backpressure: rsp_ready=0 for 5 cycles with req1 SUB 9-9 and req2 SLT -1<1 queued -> req_ready=0 once 2 in flight, rsp holds id=1,result=0,zero=1. On release, next rsp is id=2, result=1, no loss or duplication.
//  4. Reset mid-flight: accept 2 ops, assert rst_n=0 one cycle -> rsp_valid=0, rr_ptr=0, no stale response after release.
//  5. Starvation/ptr: only req3 valid, then req0 and req3 -> grants 3, then 0 (ptr wrapped to 0), then 3.
//  6. With ALU_OPISO_EN: idle 10 cycles with random req_op_* and req_valid=0 -> alu_operand_a/b/control stay 0. Without it, responses match build 1 bit-exactly.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters, with EX and RSP stages.
// Optional build macro ALU_OPISO_EN: EX operands load only on accept and ALU inputs are held at 0 while EX is idle.
module alu_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_op_a,
    input  logic [NREQ*WIDTH-1:0] req_op_b,
    input  logic [NREQ*5-1:0]     req_ctrl,
    output logic [WIDTH-1:0]      alu_operand_a,
    output logic [WIDTH-1:0]      alu_operand_b,
    output logic [4:0]            alu_control,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero
);

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0] ex_a_q, ex_a_d;
    logic [WIDTH-1:0] ex_b_q, ex_b_d;
    logic [4:0]       ex_ctrl_q, ex_ctrl_d;
    logic [IDW-1:0]   ex_id_q, ex_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic             rsp_free;
    logic             ex_adv;
    logic             accept;
    logic             hi_found;
    logic             lo_found;
    logic [IDW-1:0]   hi_idx;
    logic [IDW-1:0]   lo_idx;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [4:0]       sel_ctrl;

    assign rsp_free = !rsp_valid_q || rsp_ready;
    assign ex_adv   = !ex_valid_q || rsp_free;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
                if (IDW'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : (lo_found ? lo_idx : rr_ptr_q);
    end

    assign accept = lo_found && ex_adv && rst_n;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_ctrl  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                req_ready[i] = accept;
                sel_a        = req_op_a[i*WIDTH +: WIDTH];
                sel_b        = req_op_b[i*WIDTH +: WIDTH];
                sel_ctrl     = req_ctrl[i*5 +: 5];
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        ex_valid_d   = ex_valid_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_id_d      = ex_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;

        if (accept) begin
            rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
        if (ex_adv) begin
            ex_valid_d = accept;
        end
`ifdef ALU_OPISO_EN
        if (accept) begin
            ex_a_d    = sel_a;
            ex_b_d    = sel_b;
            ex_ctrl_d = sel_ctrl;
            ex_id_d   = grant_idx;
        end
`else
        if (ex_adv) begin
            ex_a_d    = sel_a;
            ex_b_d    = sel_b;
            ex_ctrl_d = sel_ctrl;
            ex_id_d   = grant_idx;
        end
`endif
        // A drain and a refill of RSP in the same cycle keeps rsp_valid high.
        if (ex_valid_q && rsp_free) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_id_d     = ex_id_q;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            ex_valid_q   <= 1'b0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_ctrl_q    <= '0;
            ex_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            ex_valid_q   <= ex_valid_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_id_q      <= ex_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

`ifdef ALU_OPISO_EN
    assign alu_operand_a = ex_valid_q ? ex_a_q : '0;
    assign alu_operand_b = ex_valid_q ? ex_b_q : '0;
    assign alu_control   = ex_valid_q ? ex_ctrl_q : '0;
`else
    assign alu_operand_a = ex_a_q;
    assign alu_operand_b = ex_b_q;
    assign alu_control   = ex_ctrl_q;
`endif

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: reference ALU, arbitration model and response scoreboard.
// Build with ALU_OPISO_EN defined to also exercise the idle operand-isolation behaviour.
module tb_alu_share_arbiter;

    localparam int WIDTH = 64;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] result;
        logic             zero;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_op_a = '0;
    logic [NREQ*WIDTH-1:0] req_op_b = '0;
    logic [NREQ*5-1:0]     req_ctrl = '0;
    logic [WIDTH-1:0]      alu_operand_a;
    logic [WIDTH-1:0]      alu_operand_b;
    logic [4:0]            alu_control;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_zero;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_zero;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   model_ptr = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ctrl(req_ctrl),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_ref(input logic [4:0] c, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (c)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            5'd6:    return (a < b) ? WIDTH'(1) : '0;
            5'd7:    return a << b[5:0];
            5'd8:    return a >> b[5:0];
            5'd9:    return WIDTH'($signed(a) >>> b[5:0]);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_ref(alu_control, alu_operand_a, alu_operand_b);
        alu_zero   = (alu_result == '0);
    end

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic set_op(input int r, input logic [4:0] c, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        req_ctrl[r*5 +: 5]         = c;
        req_op_a[r*WIDTH +: WIDTH] = a;
        req_op_b[r*WIDTH +: WIDTH] = b;
    endtask

    // Record accepts (expected, from the model) and response handshakes (observed) mid-cycle.
    task automatic step();
        rsp_t e;
        rsp_t o;
        int   g;
        @(negedge clk);
        if (rst_n) begin
            if ((req_valid & req_ready) != '0) begin
                g        = model_grant(req_valid, model_ptr);
                e.id     = IDW'(g);
                e.result = alu_ref(req_ctrl[g*5 +: 5], req_op_a[g*WIDTH +: WIDTH], req_op_b[g*WIDTH +: WIDTH]);
                e.zero   = (e.result == '0);
                exp_q.push_back(e);
                model_ptr = (g + 1) % NREQ;
            end
            if (rsp_valid && rsp_ready) begin
                o.id     = rsp_id;
                o.result = rsp_result;
                o.zero   = rsp_zero;
                obs_q.push_back(o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        model_ptr = 0;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        for (int r = 0; r < NREQ; r++) set_op(r, 5'd0, {$urandom, $urandom}, {$urandom, $urandom});
        #1;
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b, expected 0000", req_ready);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp: got valid=%b id=%0d result=%h zero=%b, expected all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        n_checks++;
        if ({alu_operand_a, alu_operand_b, alu_control} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_alu_in: got a=%h b=%h ctrl=%h, expected 0", alu_operand_a, alu_operand_b, alu_control);
        end
        do_reset();
    endtask

    task automatic test_single();
        rsp_t e;
        rsp_t o;
        do_reset();
        set_op(0, 5'd0, 64'd5, 64'd7);
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL single_ready: got %b, expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_early: rsp_valid got %b, expected 0", rsp_valid);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 2'd0, 64'd12, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL single_rsp: got valid=%b id=%0d result=%0d zero=%b, expected 1/0/12/0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL single_sb: got id=%0d result=%h zero=%b, expected id=%0d result=%h zero=%b",
                         o.id, o.result, o.zero, e.id, e.result, e.zero);
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL single_count: got %0d extra responses, expected 0 (%0d missing)", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        rsp_t e;
        rsp_t o;
        logic [IDW-1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            for (int r = 0; r < NREQ; r++) set_op(r, 5'($urandom_range(0, 9)), {$urandom, $urandom}, {$urandom, $urandom});
            #1;
            if (c >= 2) begin
                n_checks++;
                if (rsp_valid !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL rr_throughput cycle %0d: rsp_valid got %b, expected 1", c, rsp_valid);
                end
            end
            step();
        end
        drain();
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (k >= obs_q.size()) begin
                n_fail++;
                $display("[TB] FAIL rr_seq[%0d]: got no response, expected id %0d", k, seq[k]);
            end else if (obs_q[k].id !== seq[k]) begin
                n_fail++;
                $display("[TB] FAIL rr_seq[%0d]: got id %0d, expected id %0d", k, obs_q[k].id, seq[k]);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL rr_sb: got id=%0d result=%h zero=%b, expected id=%0d result=%h zero=%b",
                         o.id, o.result, o.zero, e.id, e.result, e.zero);
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL rr_count: got %0d extra responses, expected 0 (%0d missing)", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        rsp_t e;
        rsp_t o;
        do_reset();
        rsp_ready = 1'b0;
        set_op(1, 5'd1, 64'd9, 64'd9);
        set_op(2, 5'd5, '1, 64'd1);
        set_op(0, 5'd0, 64'd100, 64'd23);
        req_valid = 4'b0110;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL bp_grant1: got %b, expected 0010", req_ready);
        end
        step();
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({rsp_valid, req_ready, rsp_id, rsp_result, rsp_zero} !== {1'b1, 4'b0000, 2'd1, 64'd0, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid=%b ready=%b id=%0d result=%h zero=%b, expected 1/0000/1/0/1",
                         c, rsp_valid, req_ready, rsp_id, rsp_result, rsp_zero);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 2'd2, 64'd1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL bp_release: got valid=%b id=%0d result=%h zero=%b, expected 1/2/1/0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL bp_sb: got id=%0d result=%h zero=%b, expected id=%0d result=%h zero=%b",
                         o.id, o.result, o.zero, e.id, e.result, e.zero);
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got %0d extra responses, expected 0 (%0d missing)", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        rsp_t e;
        rsp_t o;
        do_reset();
        set_op(0, 5'd0, 64'd1, 64'd2);
        set_op(1, 5'd4, 64'hff, 64'h0f);
        req_valid = 4'b0011;
        step();
        req_valid = 4'b0010;
        step();
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_ready: got %b, expected 0000", req_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_valid: got %b, expected 0", rsp_valid);
        end
        rst_n     = 1'b1;
        req_valid = '0;
        exp_q.delete();
        obs_q.delete();
        model_ptr = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (rsp_valid !== 1'b0 || obs_q.size() != 0) begin
                n_fail++;
                $display("[TB] FAIL midrst_stale cycle %0d: got valid=%b responses=%0d, expected 0/0", c, rsp_valid, obs_q.size());
            end
        end
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL midrst_ptr: got %b, expected 0001", req_ready);
        end
        step();
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL midrst_sb: got id=%0d result=%h zero=%b, expected id=%0d result=%h zero=%b",
                         o.id, o.result, o.zero, e.id, e.result, e.zero);
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL midrst_count: got %0d extra responses, expected 0 (%0d missing)", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_pointer_wrap();
        logic [NREQ-1:0] pat  [3] = '{4'b1000, 4'b1001, 4'b1001};
        logic [NREQ-1:0] want [3] = '{4'b1000, 4'b0001, 4'b1000};
        do_reset();
        for (int r = 0; r < NREQ; r++) set_op(r, 5'd3, {$urandom, $urandom}, {$urandom, $urandom});
        for (int k = 0; k < 3; k++) begin
            req_valid = pat[k];
            #1;
            n_checks++;
            if (req_ready !== want[k]) begin
                n_fail++;
                $display("[TB] FAIL wrap_grant%0d: got %b, expected %b", k, req_ready, want[k]);
            end
            step();
        end
        drain();
        n_checks++;
        if (obs_q.size() != 3 || obs_q[0].id !== 2'd3 || obs_q[1].id !== 2'd0 || obs_q[2].id !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL wrap_ids: got %0d responses, expected ids 3,0,3", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        rsp_t o;
        int   max_inflight = 0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NREQ; r++) begin
                logic [WIDTH-1:0] a;
                logic [WIDTH-1:0] b;
                b = {$urandom, $urandom};
                a = ($urandom_range(0, 3) == 0) ? b : {$urandom, $urandom};
                set_op(r, 5'($urandom_range(0, 15)), a, b);
            end
            #1;
            n_checks++;
            if (!$onehot0(req_ready)) begin
                n_fail++;
                $display("[TB] FAIL b2b_onehot cycle %0d: got %b, expected one-hot or zero", c, req_ready);
            end
            step();
            if (exp_q.size() - obs_q.size() > max_inflight) max_inflight = exp_q.size() - obs_q.size();
        end
        n_checks++;
        if (max_inflight > 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_inflight: got %0d ops in flight, expected at most 2", max_inflight);
        end
        drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL b2b_sb: got id=%0d result=%h zero=%b, expected id=%0d result=%h zero=%b",
                         o.id, o.result, o.zero, e.id, e.result, e.zero);
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d extra responses, expected 0 (%0d missing)", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_idle_isolation();
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            for (int r = 0; r < NREQ; r++) set_op(r, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            #1;
            n_checks++;
`ifdef ALU_OPISO_EN
            if ({alu_operand_a, alu_operand_b, alu_control} !== '0) begin
                n_fail++;
                $display("[TB] FAIL iso_idle cycle %0d: got a=%h b=%h ctrl=%h, expected 0", c, alu_operand_a, alu_operand_b, alu_control);
            end
`else
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL idle_rsp cycle %0d: rsp_valid got %b, expected 0", c, rsp_valid);
            end
`endif
            step();
        end
    endtask

    initial begin
        $display("[TB] starting alu_share_arbiter bench");
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_pointer_wrap();
        test_back_to_back();
        test_idle_isolation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
